// File: rtl/seg_display_scroll_buffer_pkg.sv
// seg_display_pkg: shared digit-code constants and scroll mode encodings
package seg_display_pkg;
  localparam int SEG_W_DEF = 7;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {
    MODE_MANUAL     = 2'b00,
    MODE_ROTATE     = 2'b01,
    MODE_SCROLL_OUT = 2'b10,
    MODE_HOLD       = 2'b11
  } mode_e;
endpackage

// File: rtl/seg_display_scroll_buffer_if.sv
// seg_display_scroll_buffer_if: control, push handshake and display outputs of the scroll buffer
interface seg_display_scroll_buffer_if
  import seg_display_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF,
  parameter int DEPTH = 6
);
  localparam int CW = $clog2(DEPTH + 1);
  logic clear;
  mode_e mode;
  logic push_valid;
  logic push_ready;
  logic [SEG_W-1:0] din;
  logic [DEPTH*SEG_W-1:0] digits;
  logic [CW-1:0] count;
  logic full;
  logic step;
  modport master(output clear, mode, push_valid, din, input push_ready, digits, count, full, step);
  modport slave(input clear, mode, push_valid, din, output push_ready, digits, count, full, step);
endinterface

// File: rtl/seg_scroll_tick_gen.sv
// seg_scroll_tick_gen: scroll prescaler; a restart cycle holds it at zero so a full interval follows
module seg_scroll_tick_gen #(
  parameter int SCROLL_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);
  localparam int PW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
  logic [PW-1:0] r_pre;
  assign tick = run && !restart && r_pre == PW'(SCROLL_DIV - 1);
  always_ff @(posedge clock)
    r_pre <= (reset || restart || !run || tick) ? '0 : r_pre + PW'(1);
endmodule

// File: rtl/seg_display_scroll_buffer.sv
// seg_display_scroll_buffer: digit-code shift buffer with push handshake, occupancy and timed scrolling
module seg_display_scroll_buffer
  import seg_display_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF,
  parameter int DEPTH = 6,
  parameter logic [SEG_W-1:0] BLANK = SEG_W'(SEG_BLANK),
  parameter int SCROLL_DIV = 50000000
) (
  input logic clock,
  input logic reset,
  seg_display_scroll_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [SEG_W-1:0] r_cells [DEPTH];
  logic [CW-1:0] r_count;
  mode_e r_mode;
  logic r_step;
  logic w_run, w_restart, w_tick, w_push;
  logic [SEG_W-1:0] w_cell0;
  logic [CW-1:0] w_count_nxt;
  assign w_run = bus.mode == MODE_ROTATE || bus.mode == MODE_SCROLL_OUT;
  assign w_restart = bus.clear || bus.mode != r_mode;
  assign bus.push_ready = bus.mode == MODE_MANUAL && !reset && !bus.clear;
  assign w_push = bus.push_valid && bus.push_ready;
  assign w_cell0 = w_push ? bus.din : bus.mode == MODE_ROTATE ? r_cells[DEPTH-1] : BLANK;
  assign w_count_nxt = w_push ? (r_count == CW'(DEPTH) ? r_count : r_count + CW'(1))
                     : (bus.mode == MODE_SCROLL_OUT && r_count != '0) ? r_count - CW'(1) : r_count;
  seg_scroll_tick_gen #(.SCROLL_DIV(SCROLL_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .run(w_run),
    .restart(w_restart),
    .tick(w_tick)
  );
  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      for (int i = 0; i < DEPTH; i++) r_cells[i] <= BLANK;
      r_count <= '0;
    end else if (w_push || w_tick) begin
      r_cells[0] <= w_cell0;
      for (int i = 1; i < DEPTH; i++) r_cells[i] <= r_cells[i-1];
      r_count <= w_count_nxt;
    end
  end
  always_ff @(posedge clock) begin
    r_mode <= reset ? MODE_MANUAL : bus.mode;
    r_step <= !reset && w_tick;
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_dig
    assign bus.digits[g*SEG_W +: SEG_W] = r_cells[g];
  end
  assign bus.count = r_count;
  assign bus.full = r_count == CW'(DEPTH);
  assign bus.step = r_step;
endmodule

// File: tb/tb_seg_display_scroll_buffer.sv
// tb_seg_display_scroll_buffer: directed stimulus with a behavioural model feeding an expectation queue
module tb_seg_display_scroll_buffer;
  import seg_display_pkg::*;
  localparam int DIV = 4;
  typedef struct {
    logic [41:0] dig;
    int cnt;
    logic full;
    logic step;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_chk = 0;
  exp_t q[$];
  logic [6:0] m_cells [6];
  int m_cnt, m_pre;
  mode_e m_prev;
  logic m_step;
  int first;
  logic [6:0] vals [7] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  always #5 clk = ~clk;
  seg_display_scroll_buffer_if #(.SEG_W(7), .DEPTH(6)) a ();
  seg_display_scroll_buffer_if #(.SEG_W(7), .DEPTH(6)) b ();
  seg_display_scroll_buffer #(.SEG_W(7), .DEPTH(6), .BLANK(7'h7F), .SCROLL_DIV(DIV)) dut (
    .clock(clk), .reset(rst), .bus(a.slave));
  seg_display_scroll_buffer #(.SEG_W(7), .DEPTH(6), .BLANK(7'h7F), .SCROLL_DIV(1)) dut1 (
    .clock(clk), .reset(rst), .bus(b.slave));
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cyc();
    exp_t e;
    logic run, rs, tk;
    logic [6:0] last;
    if (rst || a.clear) begin
      for (int i = 0; i < 6; i++) m_cells[i] = 7'h7F;
      m_cnt = 0;
      m_pre = 0;
      m_step = 0;
      m_prev = rst ? MODE_MANUAL : a.mode;
    end else begin
      run = a.mode == MODE_ROTATE || a.mode == MODE_SCROLL_OUT;
      rs = a.mode != m_prev;
      tk = run && !rs && m_pre == DIV - 1;
      last = m_cells[5];
      if ((a.push_valid && a.mode == MODE_MANUAL) || tk) begin
        for (int i = 5; i > 0; i--) m_cells[i] = m_cells[i-1];
        if (!tk) begin
          m_cells[0] = a.din;
          m_cnt = m_cnt < 6 ? m_cnt + 1 : 6;
        end else if (a.mode == MODE_ROTATE) m_cells[0] = last;
        else begin
          m_cells[0] = 7'h7F;
          m_cnt = m_cnt > 0 ? m_cnt - 1 : 0;
        end
      end
      m_pre = (!run || rs || tk) ? 0 : m_pre + 1;
      m_step = tk;
      m_prev = a.mode;
    end
    for (int i = 0; i < 6; i++) e.dig[i*7 +: 7] = m_cells[i];
    e.cnt = m_cnt;
    e.full = m_cnt == 6;
    e.step = m_step;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("digits", 64'(a.digits), 64'(e.dig));
    check("count", 64'(a.count), 64'(e.cnt));
    check("full", 64'(a.full), 64'(e.full));
    check("step", 64'(a.step), 64'(e.step));
  endtask
  task automatic push(logic [6:0] d);
    a.push_valid = 1'b1;
    a.din = d;
    cyc();
    a.push_valid = 1'b0;
  endtask
  initial begin
    a.clear = 0; a.mode = MODE_MANUAL; a.push_valid = 0; a.din = '0;
    b.clear = 0; b.mode = MODE_MANUAL; b.push_valid = 0; b.din = '0;
    #1;
    check("ready_in_reset", 64'(a.push_ready), 64'(0));
    cyc();
    cyc();
    check("reset_digits", 64'(a.digits), 64'({6{7'h7F}}));
    rst = 0;
    #1;
    check("ready_manual", 64'(a.push_ready), 64'(1));
    for (int i = 0; i < 7; i++) push(vals[i]);
    check("seven_pushes", 64'(a.digits), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
    check("full_after_7", 64'(a.full), 64'(1));
    a.mode = MODE_ROTATE;
    a.push_valid = 1;
    a.din = 7'h55;
    #1;
    check("ready_rotate", 64'(a.push_ready), 64'(0));
    for (int i = 0; i < 5; i++) cyc();
    check("rotate_one", 64'(a.digits), 64'({7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h79}));
    for (int i = 0; i < 4; i++) cyc();
    a.push_valid = 0;
    a.mode = MODE_SCROLL_OUT;
    for (int i = 0; i < 29; i++) cyc();
    check("scroll_out_empty", 64'(a.digits), 64'({6{7'h7F}}));
    check("scroll_out_cnt", 64'(a.count), 64'(0));
    a.mode = MODE_MANUAL;
    push(7'h11);
    push(7'h22);
    a.clear = 1; a.push_valid = 1; a.din = 7'h40;
    #1;
    check("ready_clear", 64'(a.push_ready), 64'(0));
    cyc();
    a.clear = 0; a.push_valid = 0;
    check("clear_digits", 64'(a.digits), 64'({6{7'h7F}}));
    check("clear_cnt", 64'(a.count), 64'(0));
    for (int i = 0; i < 3; i++) push(vals[i]);
    a.mode = MODE_ROTATE;
    for (int i = 0; i < 6; i++) cyc();
    rst = 1;
    cyc();
    check("reset_mid_digits", 64'(a.digits), 64'({6{7'h7F}}));
    check("reset_mid_step", 64'(a.step), 64'(0));
    rst = 0;
    a.mode = MODE_MANUAL;
    for (int i = 1; i < 7; i++) push(vals[i]);
    a.mode = MODE_ROTATE;
    for (int i = 0; i < 3; i++) cyc();
    a.mode = MODE_HOLD;
    for (int i = 0; i < 2; i++) cyc();
    a.mode = MODE_ROTATE;
    first = -1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (a.step && first < 0) first = k;
    end
    check("reentry_step_idx", 64'(first), 64'(4));
    a.mode = MODE_HOLD;
    b.mode = MODE_ROTATE;
    cyc();
    check("div1_restart", 64'(b.step), 64'(0));
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("div1_step", 64'(b.step), 64'(1));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
